// File: rtl/fdtd_data_realign.sv
// Re-aligns two skewed FDTD operand streams into in-order A/B pairs.
// Each stream is buffered in its own FIFO; a pair leaves only when both heads are present.
module fdtd_data_realign #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clear_i,
  input  logic                  a_valid_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  b_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_a_o,
  output logic [DATA_WIDTH-1:0] out_b_o,
  input  logic                  out_ready_i,
  output logic [LVL_W-1:0]      a_level_o,
  output logic [LVL_W-1:0]      b_level_o,
  output logic                  err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] aMem_q [DEPTH];
  logic [DATA_WIDTH-1:0] bMem_q [DEPTH];

  logic [PTR_W-1:0]      aWrPtr_q, aWrPtr_d, aRdPtr_q, aRdPtr_d;
  logic [PTR_W-1:0]      bWrPtr_q, bWrPtr_d, bRdPtr_q, bRdPtr_d;
  logic [LVL_W-1:0]      aLevel_q, aLevel_d, bLevel_q, bLevel_d;
  logic                  outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0] outA_q, outA_d, outB_q, outB_d;
  logic                  err_q, err_d;

  logic aPush, bPush, pop;

  // Ready depends only on registered level, so a full FIFO never accepts even while popping.
  assign a_ready_o = (aLevel_q < LVL_W'(DEPTH));
  assign b_ready_o = (bLevel_q < LVL_W'(DEPTH));

  assign aPush = a_valid_i && a_ready_o;
  assign bPush = b_valid_i && b_ready_o;
  assign pop   = (aLevel_q != '0) && (bLevel_q != '0) && (!outValid_q || out_ready_i);

  always_comb begin
    aWrPtr_d   = aWrPtr_q;
    aRdPtr_d   = aRdPtr_q;
    bWrPtr_d   = bWrPtr_q;
    bRdPtr_d   = bRdPtr_q;
    aLevel_d   = aLevel_q + LVL_W'(aPush) - LVL_W'(pop);
    bLevel_d   = bLevel_q + LVL_W'(bPush) - LVL_W'(pop);
    outValid_d = outValid_q;
    outA_d     = outA_q;
    outB_d     = outB_q;
    err_d      = err_q | (a_valid_i & ~a_ready_o) | (b_valid_i & ~b_ready_o);

    if (aPush) aWrPtr_d = aWrPtr_q + PTR_W'(1);
    if (bPush) bWrPtr_d = bWrPtr_q + PTR_W'(1);

    if (pop) begin
      aRdPtr_d   = aRdPtr_q + PTR_W'(1);
      bRdPtr_d   = bRdPtr_q + PTR_W'(1);
      outA_d     = aMem_q[aRdPtr_q];
      outB_d     = bMem_q[bRdPtr_q];
      outValid_d = 1'b1;
    end else if (out_ready_i) begin
      outValid_d = 1'b0;
    end

    // Flush wins over everything on this edge; the output data registers keep their last value.
    if (clear_i) begin
      aWrPtr_d   = '0;
      aRdPtr_d   = '0;
      bWrPtr_d   = '0;
      bRdPtr_d   = '0;
      aLevel_d   = '0;
      bLevel_d   = '0;
      outValid_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (aPush && !clear_i) aMem_q[aWrPtr_q] <= a_data_i;
    if (bPush && !clear_i) bMem_q[bWrPtr_q] <= b_data_i;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      aWrPtr_q   <= '0;
      aRdPtr_q   <= '0;
      bWrPtr_q   <= '0;
      bRdPtr_q   <= '0;
      aLevel_q   <= '0;
      bLevel_q   <= '0;
      outValid_q <= 1'b0;
      outA_q     <= '0;
      outB_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      aWrPtr_q   <= aWrPtr_d;
      aRdPtr_q   <= aRdPtr_d;
      bWrPtr_q   <= bWrPtr_d;
      bRdPtr_q   <= bRdPtr_d;
      aLevel_q   <= aLevel_d;
      bLevel_q   <= bLevel_d;
      outValid_q <= outValid_d;
      outA_q     <= outA_d;
      outB_q     <= outB_d;
      err_q      <= err_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_a_o     = outA_q;
  assign out_b_o     = outB_q;
  assign a_level_o   = aLevel_q;
  assign b_level_o   = bLevel_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fdtd_data_realign.sv
// Scoreboard bench for fdtd_data_realign: stimulus queues expected pairs,
// a negedge monitor pops and compares every accepted output pair.
module tb_fdtd_data_realign;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             clear_i;
  logic             a_valid_i, b_valid_i;
  logic [DW-1:0]    a_data_i, b_data_i;
  logic             a_ready_o, b_ready_o;
  logic             out_valid_o;
  logic [DW-1:0]    out_a_o, out_b_o;
  logic             out_ready_i;
  logic [LVL_W-1:0] a_level_o, b_level_o;
  logic             err_o;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [2*DW-1:0] sb[$];

  fdtd_data_realign #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .clear_i(clear_i),
    .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .out_valid_o(out_valid_o), .out_a_o(out_a_o), .out_b_o(out_b_o),
    .out_ready_i(out_ready_i), .a_level_o(a_level_o), .b_level_o(b_level_o),
    .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's worth of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic av, input logic [DW-1:0] ad,
                               input logic bv, input logic [DW-1:0] bd, input logic rdy);
    a_valid_i   = av;
    a_data_i    = ad;
    b_valid_i   = bv;
    b_data_i    = bd;
    out_ready_i = rdy;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a pair is transferred on the next edge whenever valid and ready are both high.
  always @(negedge CLK) begin
    if (RST_N && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedPair: got a=0x%0h b=0x%0h, expected none", out_a_o, out_b_o);
      end else begin
        logic [2*DW-1:0] exp;
        exp = sb.pop_front();
        checkOutput("pairA", out_a_o, exp[2*DW-1:DW]);
        checkOutput("pairB", out_b_o, exp[DW-1:0]);
      end
    end
  end

  initial begin
    int expAL[8];
    int expBL[8];
    int expV[8];

    RST_N = 1'b0;
    clear_i = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    a_data_i = '0; b_data_i = '0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rstValid", 32'(out_valid_o), 0);
    checkOutput("rstOutA", out_a_o, 0);
    checkOutput("rstOutB", out_b_o, 0);
    checkOutput("rstALevel", 32'(a_level_o), 0);
    checkOutput("rstErr", 32'(err_o), 0);
    RST_N = 1'b1;
    #1;
    checkOutput("rstAReady", 32'(a_ready_o), 1);
    checkOutput("rstBReady", 32'(b_ready_o), 1);
    @(posedge CLK);
    #1;

    // Equal latency: one pair per clock, first pair one cycle after first push.
    for (int i = 0; i < 8; i++) sb.push_back({32'h11 + 32'(i), 32'h11 + 32'(i)});
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h11 + 32'(i), 1'b1, 32'h11 + 32'(i), 1'b1);
      checkOutput("eqValid", 32'(out_valid_o), (i >= 1) ? 1 : 0);
      checkOutput("eqALevel", 32'(a_level_o), 1);
      checkOutput("eqBLevel", 32'(b_level_o), 1);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("eqLastValid", 32'(out_valid_o), 1);
    checkOutput("eqDrainLevel", 32'(a_level_o), 0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("eqIdleValid", 32'(out_valid_o), 0);

    // Skew: A leads B by three cycles.
    expAL = '{1, 2, 3, 4, 3, 2, 1, 0};
    expBL = '{0, 0, 0, 1, 1, 1, 1, 0};
    expV  = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 4; i++) sb.push_back({32'hA0 + 32'(i), 32'hB0 + 32'(i)});
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i <= 3, 32'hA0 + 32'(i), (i >= 3) && (i <= 6), 32'hB0 + 32'(i) - 32'd3, 1'b1);
      checkOutput("skewALevel", 32'(a_level_o), 32'(expAL[i]));
      checkOutput("skewBLevel", 32'(b_level_o), 32'(expBL[i]));
      checkOutput("skewValid", 32'(out_valid_o), 32'(expV[i]));
      if (i == 3) checkOutput("skewAReadyFull", 32'(a_ready_o), 0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("skewIdleValid", 32'(out_valid_o), 0);
    checkOutput("skewErr", 32'(err_o), 0);

    // Backpressure: output held while both FIFOs fill to DEPTH.
    for (int i = 0; i < 5; i++) sb.push_back({32'h100 + 32'(i), 32'h200 + 32'(i)});
    expAL = '{1, 1, 2, 3, 4, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 32'h200 + 32'(i), 1'b0);
      checkOutput("bpALevel", 32'(a_level_o), 32'(expAL[i]));
      checkOutput("bpBLevel", 32'(b_level_o), 32'(expAL[i]));
      if (i >= 1) begin
        checkOutput("bpHoldValid", 32'(out_valid_o), 1);
        checkOutput("bpHoldA", out_a_o, 32'h100);
        checkOutput("bpHoldB", out_b_o, 32'h200);
      end
    end
    checkOutput("bpAReady", 32'(a_ready_o), 0);
    checkOutput("bpBReady", 32'(b_ready_o), 0);
    expAL = '{3, 2, 1, 0, 0, 0, 0, 0};
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("bpDrainLevel", 32'(a_level_o), 32'(expAL[j]));
      checkOutput("bpDrainValid", 32'(out_valid_o), (j < 4) ? 1 : 0);
    end
    checkOutput("bpRetainA", out_a_o, 32'h104);

    // Full: fifth A sample offered while full flags an error and waits.
    for (int i = 0; i < 5; i++) sb.push_back({32'h300 + 32'(i), 32'h400 + 32'(i)});
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, '0, 1'b1);
    checkOutput("fullALevel", 32'(a_level_o), 4);
    checkOutput("fullAReady", 32'(a_ready_o), 0);
    checkOutput("fullErrBefore", 32'(err_o), 0);
    applyStimulus(1'b1, 32'h304, 1'b0, '0, 1'b1);
    checkOutput("fullErrSet", 32'(err_o), 1);
    checkOutput("fullALevelHeld", 32'(a_level_o), 4);
    applyStimulus(1'b1, 32'h304, 1'b1, 32'h400, 1'b1);
    checkOutput("fullBLevel", 32'(b_level_o), 1);
    applyStimulus(1'b1, 32'h304, 1'b0, '0, 1'b1);
    checkOutput("fullPopLevel", 32'(a_level_o), 3);
    checkOutput("fullPopValid", 32'(out_valid_o), 1);
    applyStimulus(1'b1, 32'h304, 1'b0, '0, 1'b1);
    checkOutput("full5thAccepted", 32'(a_level_o), 4);
    for (int j = 1; j < 5; j++) applyStimulus(1'b0, '0, 1'b1, 32'h400 + 32'(j), 1'b1);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("fullDrainA", 32'(a_level_o), 0);
    checkOutput("fullDrainB", 32'(b_level_o), 0);
    checkOutput("fullErrSticky", 32'(err_o), 1);

    // Clear mid-stream with A=3, B=1 and a pair waiting on the output.
    applyStimulus(1'b1, 32'h500, 1'b1, 32'h600, 1'b0);
    applyStimulus(1'b1, 32'h501, 1'b1, 32'h601, 1'b0);
    applyStimulus(1'b1, 32'h502, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h503, 1'b0, '0, 1'b0);
    checkOutput("preClrALevel", 32'(a_level_o), 3);
    checkOutput("preClrBLevel", 32'(b_level_o), 1);
    checkOutput("preClrValid", 32'(out_valid_o), 1);
    checkOutput("preClrOutA", out_a_o, 32'h500);
    clear_i = 1'b1;
    applyStimulus(1'b1, 32'h504, 1'b1, 32'h602, 1'b0);
    clear_i = 1'b0;
    checkOutput("clrALevel", 32'(a_level_o), 0);
    checkOutput("clrBLevel", 32'(b_level_o), 0);
    checkOutput("clrValid", 32'(out_valid_o), 0);
    checkOutput("clrErr", 32'(err_o), 0);
    checkOutput("clrAReady", 32'(a_ready_o), 1);
    checkOutput("clrBReady", 32'(b_ready_o), 1);
    checkOutput("clrRetainA", out_a_o, 32'h500);
    sb.push_back({32'h777, 32'h888});
    applyStimulus(1'b1, 32'h777, 1'b1, 32'h888, 1'b1);
    checkOutput("postClrValid0", 32'(out_valid_o), 0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("postClrValid1", 32'(out_valid_o), 1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("postClrIdle", 32'(out_valid_o), 0);

    // Asynchronous reset pulse with data buffered.
    applyStimulus(1'b1, 32'h931, 1'b1, 32'h941, 1'b0);
    applyStimulus(1'b1, 32'h932, 1'b0, '0, 1'b0);
    checkOutput("preRstValid", 32'(out_valid_o), 1);
    checkOutput("preRstALevel", 32'(a_level_o), 1);
    a_valid_i = 1'b0;
    #3;
    RST_N = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(out_valid_o), 0);
    checkOutput("asyncRstOutA", out_a_o, 0);
    checkOutput("asyncRstOutB", out_b_o, 0);
    checkOutput("asyncRstALevel", 32'(a_level_o), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    checkOutput("relAReady", 32'(a_ready_o), 1);
    checkOutput("relBReady", 32'(b_ready_o), 1);
    applyStimulus(1'b0, '0, 1'b1, 32'h942, 1'b1);
    checkOutput("relBLevel", 32'(b_level_o), 1);
    checkOutput("relALevel", 32'(a_level_o), 0);
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("noStalePair", 32'(out_valid_o), 0);
    end

    checkOutput("sbEmpty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
